// File: rtl/rv_instr_encoder.sv
// Packs decoded RV32I micro-op fields into 32-bit instruction words, buffers them
// in a small FIFO and presents each word with its incrementing program address.
module rv_instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [3:0]  i_class,
  input  logic [3:0]  i_alu_op,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_addr,
  output logic        o_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0] CLS_R   = 4'd0;
  localparam logic [3:0] CLS_I   = 4'd1;
  localparam logic [3:0] CLS_LD  = 4'd2;
  localparam logic [3:0] CLS_S   = 4'd3;
  localparam logic [3:0] CLS_B   = 4'd4;
  localparam logic [3:0] CLS_J   = 4'd5;
  localparam logic [3:0] CLS_JR  = 4'd6;
  localparam logic [3:0] CLS_U   = 4'd7;
  localparam logic [3:0] CLS_UPC = 4'd8;

  // ALU codes shared with the decoder
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_S   = 7'b0100011;
  localparam logic [6:0] OPC_B   = 7'b1100011;
  localparam logic [6:0] OPC_J   = 7'b1101111;
  localparam logic [6:0] OPC_JR  = 7'b1100111;
  localparam logic [6:0] OPC_U   = 7'b0110111;
  localparam logic [6:0] OPC_UPC = 7'b0010111;

  logic        st_valid;
  logic [3:0]  st_class;
  logic [3:0]  st_op;
  logic [2:0]  st_f3;
  logic [4:0]  st_rd;
  logic [4:0]  st_rs1;
  logic [4:0]  st_rs2;
  logic [31:0] st_imm;

  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   pc;

  logic [AW+1:0] occ;
  logic          accept;
  logic          push;
  logic          pop;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic [2:0]  alu_f3;
  logic        alu_ok;
  logic [6:0]  funct7;
  logic        is_shift;
  logic [11:0] imm_i;

  // The stage slot counts toward occupancy so an accepted op always has room to land
  assign occ     = {1'b0, count} + (AW + 2)'(st_valid);
  assign o_ready = !i_clear && (occ < (AW + 2)'(DEPTH));
  assign accept  = i_valid && o_ready;
  assign o_valid = (count != '0);
  assign pop     = o_valid && i_ready;
  assign push    = st_valid && enc_legal;
  assign o_err   = st_valid && !enc_legal && !i_clear;
  assign o_instr = o_valid ? mem[rd_ptr] : 32'h0;
  assign o_addr  = pc;

  always_comb begin
    alu_f3 = 3'b000;
    alu_ok = 1'b1;
    case (st_op)
      ALU_ADD, ALU_SUB: alu_f3 = 3'b000;
      ALU_SLL:          alu_f3 = 3'b001;
      ALU_SLT:          alu_f3 = 3'b010;
      ALU_SLTU:         alu_f3 = 3'b011;
      ALU_XOR:          alu_f3 = 3'b100;
      ALU_SRL, ALU_SRA: alu_f3 = 3'b101;
      ALU_OR:           alu_f3 = 3'b110;
      ALU_AND:          alu_f3 = 3'b111;
      default:          alu_ok = 1'b0;
    endcase
    funct7   = (st_op == ALU_SUB || st_op == ALU_SRA) ? 7'b0100000 : 7'b0000000;
    is_shift = (st_op == ALU_SLL || st_op == ALU_SRL || st_op == ALU_SRA);
    imm_i    = is_shift ? {funct7, st_imm[4:0]} : st_imm[11:0];
  end

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (st_class)
      CLS_R: begin
        enc_word  = {funct7, st_rs2, st_rs1, alu_f3, st_rd, OPC_R};
        enc_legal = alu_ok;
      end
      CLS_I: begin
        enc_word  = {imm_i, st_rs1, alu_f3, st_rd, OPC_I};
        enc_legal = alu_ok && (st_op != ALU_SUB);
      end
      CLS_LD:
        enc_word = {st_imm[11:0], st_rs1, st_f3, st_rd, OPC_LD};
      CLS_S:
        enc_word = {st_imm[11:5], st_rs2, st_rs1, st_f3, st_imm[4:0], OPC_S};
      CLS_B: begin
        enc_word  = {st_imm[12], st_imm[10:5], st_rs2, st_rs1, st_f3,
                     st_imm[4:1], st_imm[11], OPC_B};
        enc_legal = !st_imm[0] && (st_f3 != 3'b010) && (st_f3 != 3'b011);
      end
      CLS_J: begin
        enc_word  = {st_imm[20], st_imm[10:1], st_imm[11], st_imm[19:12], st_rd, OPC_J};
        enc_legal = !st_imm[0];
      end
      CLS_JR:
        enc_word = {st_imm[11:0], st_rs1, 3'b000, st_rd, OPC_JR};
      CLS_U:
        enc_word = {st_imm[31:12], st_rd, OPC_U};
      CLS_UPC:
        enc_word = {st_imm[31:12], st_rd, OPC_UPC};
      default:
        enc_legal = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pc       <= BASE_ADDR;
    end else if (i_clear) begin
      st_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pc       <= BASE_ADDR;
    end else begin
      st_valid <= accept;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        pc     <= pc + 32'd4;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Data path needs no reset: st_valid and count qualify every use
  always_ff @(posedge i_clk) begin
    if (accept) begin
      st_class <= i_class;
      st_op    <= i_alu_op;
      st_f3    <= i_funct3;
      st_rd    <= i_rd;
      st_rs1   <= i_rs1;
      st_rs2   <= i_rs2;
      st_imm   <= i_imm;
    end
    if (push && !i_clear) mem[wr_ptr] <= enc_word;
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: directed encodings from the test plan plus a random
// stream checked against a field-arithmetic encoder and a queue-based FIFO model.
module tb_rv_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  localparam int A_ADD = 0, A_SUB = 1, A_SLL = 2, A_SRA = 7;
  localparam int C_R = 0, C_I = 1, C_S = 3, C_B = 4, C_U = 7;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_clear = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [3:0]  i_class = '0;
  logic [3:0]  i_alu_op = '0;
  logic [2:0]  i_funct3 = '0;
  logic [4:0]  i_rd = '0, i_rs1 = '0, i_rs2 = '0;
  logic [31:0] i_imm = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_instr, o_addr;
  logic        o_err;

  rv_instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_clear(i_clear), .i_valid(i_valid), .o_ready(o_ready),
    .i_class(i_class), .i_alu_op(i_alu_op), .i_funct3(i_funct3), .i_rd(i_rd),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .o_valid(o_valid), .i_ready(i_ready),
    .o_instr(o_instr), .o_addr(o_addr), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int accepted = 0;

  logic [31:0] q[$];
  logic [31:0] m_pc = BASE;
  bit          m_pend = 0;
  bit          m_pend_ok = 0;
  logic [31:0] m_pend_word = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Encoding computed by OR-ing each field shifted to its bit position
  function automatic logic [31:0] ref_encode(input logic [31:0] cls, input logic [31:0] op,
      input logic [31:0] f3, input logic [31:0] rd, input logic [31:0] rs1,
      input logic [31:0] rs2, input logic [31:0] imm, output bit ok);
    int opc_t [9] = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h6F, 'h67, 'h37, 'h17};
    int af3_t [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    logic [31:0] w, f, alt;
    ok = 1;
    if (cls > 8) begin
      ok = 0;
      return 32'h0;
    end
    w   = opc_t[cls];
    alt = (op == 1 || op == 7) ? 32'h20 : 32'h0;
    case (cls)
      0: if (op > 9) ok = 0;
         else w |= (rd << 7) | (af3_t[op] << 12) | (rs1 << 15) | (rs2 << 20) | (alt << 25);
      1: if (op > 9 || op == 1) ok = 0;
         else begin
           if (op == 2 || op == 6 || op == 7) f = (imm & 31) | (alt << 5);
           else f = imm & 'hFFF;
           w |= (rd << 7) | (af3_t[op] << 12) | (rs1 << 15) | (f << 20);
         end
      2: w |= (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 'hFFF) << 20);
      3: w |= ((imm & 31) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (((imm >> 5) & 'h7F) << 25);
      4: if (imm[0] || f3 == 2 || f3 == 3) ok = 0;
         else w |= (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8) | (f3 << 12) |
                   (rs1 << 15) | (rs2 << 20) | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
      5: if (imm[0]) ok = 0;
         else w |= (rd << 7) | (((imm >> 12) & 255) << 12) | (((imm >> 11) & 1) << 20) |
                   (((imm >> 1) & 1023) << 21) | (((imm >> 20) & 1) << 31);
      6: w |= (rd << 7) | (rs1 << 15) | ((imm & 'hFFF) << 20);
      default: w |= (rd << 7) | (imm & 32'hFFFF_F000);
    endcase
    return w;
  endfunction

  // Called at edge+1 with inputs already driven; returns at the next edge+1
  task automatic step();
    bit exp_ready, acc, ok;
    logic [31:0] w;
    ok = 0;
    w  = '0;
    #2;
    exp_ready = !i_clear && (q.size() + int'(m_pend)) < DEPTH;
    chk("ready", 32'(o_ready), 32'(exp_ready));
    chk("valid", 32'(o_valid), 32'(q.size() != 0));
    chk("err", 32'(o_err), 32'(m_pend && !m_pend_ok && !i_clear));
    if (!i_clear && q.size() != 0 && i_ready) begin
      chk("instr", o_instr, q[0]);
      chk("addr", o_addr, m_pc);
    end
    acc = i_valid && exp_ready;
    if (acc) w = ref_encode(32'(i_class), 32'(i_alu_op), 32'(i_funct3), 32'(i_rd),
                            32'(i_rs1), 32'(i_rs2), i_imm, ok);
    @(posedge clk);
    if (i_clear) begin
      q.delete();
      m_pend = 0;
      m_pc   = BASE;
    end else begin
      if (q.size() != 0 && i_ready) begin
        void'(q.pop_front());
        m_pc += 4;
      end
      if (m_pend && m_pend_ok) q.push_back(m_pend_word);
      m_pend      = acc;
      m_pend_ok   = ok;
      m_pend_word = w;
      if (acc) accepted++;
    end
    #1;
  endtask

  task automatic drive(input int cls, input int op, input int f3, input int rd,
                       input int rs1, input int rs2, input logic [31:0] imm);
    i_valid  = 1'b1;
    i_class  = 4'(cls);
    i_alu_op = 4'(op);
    i_funct3 = 3'(f3);
    i_rd     = 5'(rd);
    i_rs1    = 5'(rs1);
    i_rs2    = 5'(rs2);
    i_imm    = imm;
  endtask

  task automatic rand_op(input bit allow_illegal);
    int cls, op, f3;
    logic [31:0] imm;
    cls = (allow_illegal && $urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
    op  = $urandom_range(0, allow_illegal ? 11 : 9);
    f3  = $urandom_range(0, 7);
    imm = $urandom;
    if (!allow_illegal && cls == C_I && op == A_SUB) op = A_ADD;
    if (!allow_illegal && cls == C_B && (f3 == 2 || f3 == 3)) f3 = 0;
    if ((cls == C_B || cls == 5) && (!allow_illegal || $urandom_range(0, 3) != 0)) imm[0] = 1'b0;
    drive(cls, op, f3, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm);
  endtask

  task automatic check_head(input logic [31:0] word, input logic [31:0] addr);
    chk("head_valid", 32'(o_valid), 32'd1);
    chk("head_instr", o_instr, word);
    chk("head_addr", o_addr, addr);
  endtask

  task automatic directed(input int cls, input int op, input int f3, input int rd, input int rs1,
                          input int rs2, input logic [31:0] imm, input logic [31:0] word,
                          input logic [31:0] addr);
    i_ready = 1'b0;
    drive(cls, op, f3, rd, rs1, rs2, imm);
    step();
    i_valid = 1'b0;
    step();
    check_head(word, addr);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
  endtask

  task automatic directed_err(input int cls, input int op, input int f3, input logic [31:0] imm);
    i_ready = 1'b0;
    drive(cls, op, f3, 1, 1, 2, imm);
    step();
    i_valid = 1'b0;
    chk("err_pulse", 32'(o_err), 32'd1);
    step();
    chk("err_single", 32'(o_err), 32'd0);
    chk("err_no_push", 32'(o_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    bit have;
    int acc0;

    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_addr", o_addr, BASE);
    @(posedge clk);
    #1;
    i_rst = 1'b0;

    directed(C_R, A_ADD, 0, 3, 1, 2, 32'h0, 32'h002081B3, 32'd0);
    directed(C_R, A_SUB, 0, 3, 1, 2, 32'h0, 32'h402081B3, 32'd4);
    directed(C_I, A_ADD, 0, 5, 0, 0, 32'hFFFF_FFFF, 32'hFFF00293, 32'd8);
    directed(C_I, A_SRA, 0, 6, 7, 0, 32'd3, 32'h4033D313, 32'd12);
    directed(C_S, A_ADD, 2, 0, 1, 2, 32'd4, 32'h0020A223, 32'd16);
    directed(C_B, A_ADD, 0, 0, 1, 2, 32'd8, 32'h00208463, 32'd20);
    directed(C_U, A_ADD, 0, 10, 0, 0, 32'h12345000, 32'h12345537, 32'd24);

    directed_err(C_B, A_ADD, 0, 32'd7);
    directed(C_R, A_ADD, 0, 3, 1, 2, 32'h0, 32'h002081B3, 32'd28);
    directed_err(C_I, A_SUB, 0, 32'd1);
    directed_err(12, A_ADD, 0, 32'd0);
    directed_err(C_B, A_ADD, 3, 32'd4);
    directed(C_I, A_SLL, 0, 1, 2, 0, 32'hFFFF_FFE5, 32'h00511093, 32'd32);

    // Backpressure: only DEPTH ops fit, head must stay frozen
    i_ready = 1'b0;
    acc0 = accepted;
    have = 0;
    held = '0;
    for (int c = 0; c < 10; c++) begin
      rand_op(1'b0);
      step();
      if (o_valid) begin
        if (!have) begin
          held = o_instr;
          have = 1;
        end else chk("hold_stable", o_instr, held);
      end
    end
    chk("hold_accepted", 32'(accepted - acc0), 32'(DEPTH));
    chk("hold_ready_low", 32'(o_ready), 32'd0);

    // Release with continuous valid: push and pop together every cycle
    i_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      rand_op(1'b0);
      step();
    end
    i_valid = 1'b0;
    for (int c = 0; c < 8; c++) step();
    chk("drained", 32'(o_valid), 32'd0);

    // Clear with three words queued
    i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rand_op(1'b0);
      step();
    end
    i_valid = 1'b0;
    step();
    chk("clear_pre_valid", 32'(o_valid), 32'd1);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    chk("clear_valid", 32'(o_valid), 32'd0);
    chk("clear_addr", o_addr, BASE);
    directed(C_R, A_ADD, 0, 3, 1, 2, 32'h0, 32'h002081B3, BASE);

    // Random traffic including illegal ops and occasional clears
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) != 0) rand_op(1'b1);
      else i_valid = 1'b0;
      i_ready = ($urandom_range(0, 2) != 0);
      i_clear = ($urandom_range(0, 39) == 0);
      step();
    end
    i_clear = 1'b0;

    // Asynchronous reset in the middle of a stream
    i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rand_op(1'b0);
      step();
    end
    i_valid = 1'b0;
    step();
    #3;
    i_rst = 1'b1;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_instr", o_instr, 32'h0);
    chk("arst_addr", o_addr, BASE);
    chk("arst_err", 32'(o_err), 32'd0);
    q.delete();
    m_pend = 0;
    m_pc   = BASE;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    directed(C_R, A_SUB, 0, 3, 1, 2, 32'h0, 32'h402081B3, BASE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
